// File: rtl/pkt_comm_pkt_builder_if.sv
// Byte-wide bus bundle: FWFT body source on one side, output FIFO write port on the other.
interface pkt_comm_pkt_builder_if;
  logic [7:0] body_din;
  logic       body_empty;
  logic       body_rd_en;
  logic [7:0] dout;
  logic       wr_en;
  logic       full;

  modport master (
    input  body_din, body_empty, full,
    output body_rd_en, dout, wr_en
  );

  modport slave (
    output body_din, body_empty, full,
    input  body_rd_en, dout, wr_en
  );
endinterface

// File: rtl/pkt_comm_pkt_builder.sv
// Serializes a pkt_comm packet (header, header checksum, body, body checksum)
// onto an 8-bit FIFO write port, pulling the body from an FWFT source.
module pkt_comm_pkt_builder #(
  parameter int unsigned VERSION          = 2,
  parameter int unsigned LEN_WIDTH        = 24,
  parameter bit          DISABLE_CHECKSUM = 1'b0
) (
  input  logic                 CLK,
  input  logic                 rst,
  input  logic                 start,
  input  logic [7:0]           pkt_type,
  input  logic [15:0]          pkt_id,
  input  logic [LEN_WIDTH-1:0] pkt_len,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  pkt_comm_pkt_builder_if.master bus
);
  localparam int unsigned CW = (LEN_WIDTH > 4) ? LEN_WIDTH : 4;

  typedef enum logic [2:0] {IDLE, HDR, HCS, BODY, BCS} state_t;

  state_t               state, nxt;
  logic [CW-1:0]        cnt;
  logic [7:0]           type_q;
  logic [15:0]          id_q;
  logic [LEN_WIDTH-1:0] len_q;
  logic [31:0]          hsum, bsum;
  logic [23:0]          len24;
  logic [7:0]           hdr_byte, cs_byte;
  logic [31:0]          cs_word;
  logic [4:0]           sh;
  logic                 last_sec;

  assign len24 = 24'(len_q);
  assign sh    = {cnt[1:0], 3'b000};

  always_comb begin
    bus.wr_en = 1'b0;
    unique case (state)
      HDR, HCS, BCS: bus.wr_en = !bus.full;
      BODY:          bus.wr_en = !bus.full && !bus.body_empty;
      default:       bus.wr_en = 1'b0;
    endcase
  end

  assign bus.body_rd_en = bus.wr_en && (state == BODY);

  always_comb begin
    hdr_byte = 8'h00;
    case (cnt[3:0])
      4'd0:    hdr_byte = 8'(VERSION);
      4'd1:    hdr_byte = type_q;
      4'd4:    hdr_byte = len24[7:0];
      4'd5:    hdr_byte = len24[15:8];
      4'd6:    hdr_byte = len24[23:16];
      4'd8:    hdr_byte = id_q[7:0];
      4'd9:    hdr_byte = id_q[15:8];
      default: hdr_byte = 8'h00;
    endcase
  end

  // Sums are complete one cycle after the last byte of their section, which is
  // exactly the first checksum cycle, so no bubble is needed.
  assign cs_word = DISABLE_CHECKSUM ? 32'h0 : ((state == HCS) ? ~hsum : ~bsum);
  assign cs_byte = 8'(cs_word >> sh);

  always_comb begin
    bus.dout = 8'h00;
    case (state)
      HDR:      bus.dout = hdr_byte;
      HCS, BCS: bus.dout = cs_byte;
      BODY:     bus.dout = bus.body_din;
      default:  bus.dout = 8'h00;
    endcase
  end

  always_comb begin
    last_sec = 1'b0;
    nxt      = IDLE;
    case (state)
      HDR:  begin last_sec = (cnt == CW'(9));               nxt = HCS;  end
      HCS:  begin last_sec = (cnt == CW'(3));               nxt = BODY; end
      BODY: begin last_sec = (cnt == CW'(len_q - 1'b1));    nxt = BCS;  end
      BCS:  begin last_sec = (cnt == CW'(3));               nxt = IDLE; end
      default: begin last_sec = 1'b0;                       nxt = IDLE; end
    endcase
  end

  assign done = bus.wr_en && (state == BCS) && last_sec;

  always_ff @(posedge CLK) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      type_q <= '0;
      id_q   <= '0;
      len_q  <= '0;
      hsum   <= '0;
      bsum   <= '0;
      busy   <= 1'b0;
      err    <= 1'b0;
    end else begin
      err <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          if (pkt_len != '0) begin
            type_q <= pkt_type;
            id_q   <= pkt_id;
            len_q  <= pkt_len;
            cnt    <= '0;
            hsum   <= '0;
            bsum   <= '0;
            busy   <= 1'b1;
            state  <= HDR;
          end else begin
            err <= 1'b1;
          end
        end
      end else if (bus.wr_en) begin
        // Each byte lands in its little-endian lane; summing shifted bytes equals summing padded words.
        if (state == HDR)  hsum <= hsum + (32'(hdr_byte) << sh);
        if (state == BODY) bsum <= bsum + (32'(bus.body_din) << sh);
        if (last_sec) begin
          cnt   <= '0;
          state <= nxt;
          if (state == BCS) busy <= 1'b0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end
endmodule
